// File: rtl/vip_pkg.sv
// Shared definitions for the VIP binning stage: state encodings, edge patterns
// and sizing helpers derived from the block parameters.
package vip_pkg;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_t;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // Edge patterns on {previous, current} samples of a strobe
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;

    function automatic int unsigned lbuf_depth(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned lbuf_aw(input int unsigned width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned bits);
        return bits + 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned bits);
        return bits + 2;
    endfunction

endpackage

// File: rtl/vip_bin_linebuf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Kept separate so it can later be swapped for an SRAM macro.
module vip_bin_linebuf #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 9
) (
    input  logic          pclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vip_bin2x2.sv
// 2x2 pixel binning for a single-channel href/vsync stream; one strobed output
// pixel per 2x2 block on odd lines. Define VIP_BIN_ROUND_EN for round-half-up.
module vip_bin2x2
    import vip_pkg::*;
#(
    parameter int unsigned BITS   = 8,
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_data,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_data
);

    localparam int unsigned LBUF_DEPTH = lbuf_depth(WIDTH);
    localparam int unsigned LBUF_AW    = lbuf_aw(WIDTH);
    localparam int unsigned SUM_W      = sum_w(BITS);
    localparam int unsigned ACC_W      = acc_w(BITS);
    localparam int unsigned IDX_W      = $clog2(LBUF_DEPTH + 1);
    localparam int unsigned LINE_W     = $clog2(HEIGHT + 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(LBUF_DEPTH);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(HEIGHT);

    logic              prev_href;
    logic              prev_vsync;
    parity_t           parity;
    phase_t            phase;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  even_pairs;
    logic [LINE_W-1:0] line_cnt;
    logic [BITS-1:0]   p0;

    logic              line_start;
    logic              line_end;
    logic              frame_start;
    phase_t            ph_cur;
    logic [IDX_W-1:0]  idx_cur;
    logic              pair_done;
    logic              line_ok;
    logic              lb_we;
    logic              emit;
    logic [SUM_W-1:0]  hsum;
    logic [SUM_W-1:0]  lb_rdata;
    logic [ACC_W-1:0]  sum;
    logic [BITS-1:0]   binned;

    // Phase and index restart on the very cycle carrying a line's first pixel
    always_comb begin
        line_start  = ({prev_href, in_href} == EDGE_RISE);
        line_end    = ({prev_href, in_href} == EDGE_FALL);
        frame_start = ({prev_vsync, in_vsync} == EDGE_FALL);
        ph_cur      = line_start ? PH_FIRST : phase;
        idx_cur     = line_start ? '0 : idx;
        pair_done   = in_href && (ph_cur == PH_SECOND);
        line_ok     = (line_cnt < LINE_MAX);
        hsum        = SUM_W'(p0) + SUM_W'(in_data);
        lb_we       = pair_done && line_ok && (parity == PAR_EVEN) && (idx_cur < IDX_MAX);
        emit        = pair_done && line_ok && (parity == PAR_ODD) && (idx_cur < even_pairs);
        sum         = ACC_W'(hsum) + ACC_W'(lb_rdata);
`ifdef VIP_BIN_ROUND_EN
        binned      = BITS'((sum + ACC_W'(2)) >> 2);
`else
        binned      = BITS'(sum >> 2);
`endif
    end

    // Read address is presented on phase 0 so the stored pair lands on phase 1
    vip_bin_linebuf #(
        .DEPTH (LBUF_DEPTH),
        .AW    (LBUF_AW),
        .DW    (SUM_W)
    ) u_linebuf (
        .pclk  (pclk),
        .we    (lb_we),
        .waddr (idx_cur[LBUF_AW-1:0]),
        .wdata (hsum),
        .raddr (idx_cur[LBUF_AW-1:0]),
        .rdata (lb_rdata)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            prev_href  <= 1'b0;
            prev_vsync <= 1'b0;
            parity     <= PAR_EVEN;
            phase      <= PH_FIRST;
            idx        <= '0;
            even_pairs <= '0;
            line_cnt   <= '0;
            p0         <= '0;
            out_href   <= 1'b0;
            out_vsync  <= 1'b0;
            out_data   <= '0;
        end else begin
            prev_href  <= in_href;
            prev_vsync <= in_vsync;
            out_vsync  <= in_vsync;

            if (in_href) begin
                phase <= (ph_cur == PH_FIRST) ? PH_SECOND : PH_FIRST;
                if (ph_cur == PH_FIRST) begin
                    p0 <= in_data;
                end
            end

            if (pair_done && (idx_cur < IDX_MAX)) begin
                idx <= idx_cur + IDX_W'(1);
            end else if (line_start) begin
                idx <= '0;
            end

            if (frame_start) begin
                parity     <= PAR_EVEN;
                line_cnt   <= '0;
                even_pairs <= '0;
            end else if (line_end) begin
                parity <= (parity == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
                if (line_ok) begin
                    line_cnt <= line_cnt + LINE_W'(1);
                    if (parity == PAR_EVEN) begin
                        even_pairs <= idx;
                    end
                end
            end

            out_href <= emit;
            out_data <= emit ? binned : '0;
        end
    end

endmodule
